// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC3 memory responder: per-port state
// encoding, program base address, latency limits and stall LFSR constants.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  // Programs are loaded and fetched starting here.
  localparam logic [15:0] BASE_ADDR = 16'h3000;

  // Largest legal configured latency for either port.
  localparam int unsigned MAX_LAT = 15;

  // Extra random stall cycles are drawn from two LFSR bits (0..3).
  localparam int unsigned MAX_STALL = 3;

  // Wait counter must hold MAX_LAT + MAX_STALL - 1 remaining cycles.
  localparam int unsigned CNT_W = 5;

  // Galois LFSR used for random stall injection.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Number of WAIT cycles between capture and RESP for a given latency.
  function automatic logic [CNT_W-1:0] wait_cycles(input int unsigned lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/lc3_mem_port_fsm.sv
// One request port of the memory responder: captures a request payload in
// IDLE, counts wait states, and strobes the access on the edge that enters
// RESP so the registered memory read lands exactly in the RESP cycle.
// Optional: LC3_MEM_STALL_RAND_EN adds 0..3 LFSR-chosen stall cycles.
module lc3_mem_port_fsm
  import lc3_mem_pkg::*;
#(
  parameter int unsigned LAT       = 1,
  parameter int unsigned PAYLOAD_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic                 fire_o,
  output logic [PAYLOAD_W-1:0] access_o,
  output logic                 resp_o
);

  port_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 fire;
  logic [1:0]           extra;
  logic [CNT_W-1:0]     wait_init;

`ifdef LC3_MEM_STALL_RAND_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois shift: free-running, one step per clock.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  // LFSR register, reseeded by reset.
  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign extra = lfsr_q[1:0];
`else
  assign extra = 2'b00;
`endif

  // Remaining WAIT cycles for a request captured this cycle; zero means
  // the access happens on the capture edge itself.
  assign wait_init = wait_cycles(LAT) + CNT_W'(extra);

  // Next-state logic; the access strobe marks the transition into RESP.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    fire      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          payload_d = payload_i;
          cnt_d     = wait_init;
          if (wait_init == '0) begin
            state_d = ST_RESP;
            fire    = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
          fire    = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A reset landing on the access edge aborts the transaction outright.
  assign fire_o   = fire & ~reset;
  // In IDLE the access may happen on the capture edge, so bypass the latch.
  assign access_o = (state_q == ST_IDLE) ? payload_i : payload_q;
  assign resp_o   = (state_q == ST_RESP);

  // State, counter and captured payload registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory responder for the LC3 core: instruction and data ports with
// configurable wait states, plus a backdoor load port for preloading.
// Optional: LC3_MEM_STALL_RAND_EN enables random 0..3 cycle extra stalls.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned INSTR_LAT = 1,
  parameter int unsigned DATA_LAT  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic        instrmem_rd,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic        data_en,
  input  logic [15:0] Data_addr,
  input  logic        Data_rd,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        ld_en,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data
);

  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam int unsigned DATA_PW   = ADDR_W + 17;

  logic [15:0] mem [0:DEPTH-1];

  logic              i_fire, i_resp;
  logic [ADDR_W-1:0] i_addr;
  logic              d_fire, d_resp;
  logic [DATA_PW-1:0] d_access;
  logic [ADDR_W-1:0] d_addr;
  logic [15:0]       d_din;
  logic              d_rd;
  logic [15:0]       instr_dout_q;
  logic [15:0]       data_dout_q;

  // Upper address bits are dropped here, giving modulo-2**ADDR_W wrap.
  lc3_mem_port_fsm #(
    .LAT       (INSTR_LAT),
    .PAYLOAD_W (ADDR_W)
  ) u_instr_port (
    .clock     (clock),
    .reset     (reset),
    .req_i     (instrmem_rd),
    .payload_i (pc[ADDR_W-1:0]),
    .fire_o    (i_fire),
    .access_o  (i_addr),
    .resp_o    (i_resp)
  );

  lc3_mem_port_fsm #(
    .LAT       (DATA_LAT),
    .PAYLOAD_W (DATA_PW)
  ) u_data_port (
    .clock     (clock),
    .reset     (reset),
    .req_i     (data_en),
    .payload_i ({Data_rd, Data_din, Data_addr[ADDR_W-1:0]}),
    .fire_o    (d_fire),
    .access_o  (d_access),
    .resp_o    (d_resp)
  );

  assign d_addr = d_access[ADDR_W-1:0];
  assign d_din  = d_access[ADDR_W+15:ADDR_W];
  assign d_rd   = d_access[ADDR_W+16];

  // Array writes: port write first, backdoor last so it wins a collision.
  // Not gated by reset, so a load during reset still lands.
  always_ff @(posedge clock) begin
    if (d_fire && !d_rd) mem[d_addr] <= d_din;
    if (ld_en)           mem[ld_addr[ADDR_W-1:0]] <= ld_data;
  end

  // Instruction read register; read sees pre-write contents on the same edge.
  always_ff @(posedge clock) begin
    if (reset)       instr_dout_q <= '0;
    else if (i_fire) instr_dout_q <= mem[i_addr];
  end

  // Data read register; holds across writes.
  always_ff @(posedge clock) begin
    if (reset)              data_dout_q <= '0;
    else if (d_fire && d_rd) data_dout_q <= mem[d_addr];
  end

  assign Instr_dout     = instr_dout_q;
  assign Data_dout      = data_dout_q;
  assign complete_instr = i_resp;
  assign complete_data  = d_resp;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: directed corner cases plus a
// randomized mix of loads, fetches, data reads and writes checked against
// an associative-array memory model.
module tb_lc3_mem_responder;

  localparam int INSTR_LAT = 1;
  localparam int DATA_LAT  = 2;
`ifdef LC3_MEM_STALL_RAND_EN
  localparam int STALL_MAX = 3;
`else
  localparam int STALL_MAX = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        instrmem_rd;
  logic [15:0] Instr_dout, Instr_dout12;
  logic        complete_instr, complete_instr12;
  logic        data_en;
  logic [15:0] Data_addr;
  logic        Data_rd;
  logic [15:0] Data_din;
  logic [15:0] Data_dout, Data_dout12;
  logic        complete_data, complete_data12;
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [15:0] ld_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model   [logic [15:0]];
  logic [15:0] model12 [logic [11:0]];
  logic [15:0] exp_data_dout;
  logic [15:0] pool [16];

  always #5 clock = ~clock;

  lc3_mem_responder #(.ADDR_W(16), .INSTR_LAT(INSTR_LAT), .DATA_LAT(DATA_LAT)) dut (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
    .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .data_en(data_en), .Data_addr(Data_addr), .Data_rd(Data_rd), .Data_din(Data_din),
    .Data_dout(Data_dout), .complete_data(complete_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  // Narrow-address instance sharing all inputs, used for wrap checks.
  lc3_mem_responder #(.ADDR_W(12), .INSTR_LAT(INSTR_LAT), .DATA_LAT(DATA_LAT)) dut12 (
    .clock(clock), .reset(reset), .pc(pc), .instrmem_rd(instrmem_rd),
    .Instr_dout(Instr_dout12), .complete_instr(complete_instr12),
    .data_en(data_en), .Data_addr(Data_addr), .Data_rd(Data_rd), .Data_din(Data_din),
    .Data_dout(Data_dout12), .complete_data(complete_data12),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic ld_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clock);
    ld_en = 1'b0;
    model[a] = d;
    model12[a[11:0]] = d;
    $display("ld    [%h] <= %h", a, d);
  endtask

  task automatic fetch(input logic [15:0] a, output logic [15:0] d, output int lat);
    @(negedge clock);
    pc = a; instrmem_rd = 1'b1;
    @(posedge clock);
    #1 instrmem_rd = 1'b0;
    lat = -1; d = '0;
    for (int i = 1; i <= 25 && lat < 0; i++) begin
      @(negedge clock);
      if (complete_instr) begin lat = i; d = Instr_dout; end
    end
  endtask

  task automatic data_req(input logic rd, input logic [15:0] a, input logic [15:0] din,
                          output logic [15:0] d, output int lat);
    @(negedge clock);
    data_en = 1'b1; Data_rd = rd; Data_addr = a; Data_din = din;
    @(posedge clock);
    #1 data_en = 1'b0;
    lat = -1; d = '0;
    for (int i = 1; i <= 25 && lat < 0; i++) begin
      @(negedge clock);
      if (complete_data) begin lat = i; d = Data_dout; end
    end
  endtask

  task automatic check_fetch(input logic [15:0] a);
    logic [15:0] d; int lat;
    fetch(a, d, lat);
    check_eq("fetch_lat", 32'(lat >= INSTR_LAT && lat <= INSTR_LAT + STALL_MAX), 32'd1);
    check_eq("fetch_data", d, model[a]);
    @(negedge clock);
    check_eq("fetch_pulse_w", complete_instr, 1'b0);
    $display("fetch [%h] -> %h lat %0d", a, d, lat);
  endtask

  task automatic check_dread(input logic [15:0] a);
    logic [15:0] d; int lat;
    data_req(1'b1, a, 16'h0000, d, lat);
    check_eq("dread_lat", 32'(lat >= DATA_LAT && lat <= DATA_LAT + STALL_MAX), 32'd1);
    check_eq("dread_data", d, model[a]);
    exp_data_dout = model[a];
    $display("dread [%h] -> %h lat %0d", a, d, lat);
  endtask

  task automatic do_dwrite(input logic [15:0] a, input logic [15:0] v);
    logic [15:0] d; int lat;
    data_req(1'b0, a, v, d, lat);
    check_eq("dwr_lat", 32'(lat >= DATA_LAT && lat <= DATA_LAT + STALL_MAX), 32'd1);
    check_eq("dwr_dout_hold", d, exp_data_dout);
    model[a] = v;
    model12[a[11:0]] = v;
    $display("dwrite[%h] <= %h lat %0d", a, v, lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    reset = 1'b1; pc = '0; instrmem_rd = 1'b0; data_en = 1'b0; Data_addr = '0;
    Data_rd = 1'b0; Data_din = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    exp_data_dout = 16'h0000;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_instr_dout", Instr_dout, 16'h0000);
    check_eq("rst_data_dout", Data_dout, 16'h0000);
    check_eq("rst_cpl_instr", complete_instr, 1'b0);
    check_eq("rst_cpl_data", complete_data, 1'b0);
    check_eq("rst12_outs", {Instr_dout12, Data_dout12, complete_instr12, complete_data12}, 34'h0);

    // Program preload and first fetch.
    ld_write(16'h3000, 16'h1261);
    check_fetch(16'h3000);

    // Data write then read back; Data_dout unchanged by the write.
    do_dwrite(16'h4000, 16'hBEEF);
    check_dread(16'h4000);

    // Same-edge instruction read and data write: read sees old contents.
    ld_write(16'h3005, 16'h0000);
    @(negedge clock);
    data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3005; Data_din = 16'h5555;
    @(posedge clock);
    #1 data_en = 1'b0; pc = 16'h3005; instrmem_rd = 1'b1;
    @(posedge clock);
    #1 instrmem_rd = 1'b0;
    @(negedge clock);
    check_eq("rbw_cpl_instr", complete_instr, 1'b1);
    check_eq("rbw_cpl_data", complete_data, 1'b1);
    check_eq("rbw_old_data", Instr_dout, 16'h0000);
    model[16'h3005] = 16'h5555;
    model12[12'h005] = 16'h5555;
    $display("rbw   [3005] fetch %h alongside write 5555", Instr_dout);
    check_fetch(16'h3005);

    // Backdoor load wins a same-edge collision with a port write.
    ld_write(16'h4030, 16'h1111);
    @(negedge clock);
    data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4030; Data_din = 16'h2222;
    @(posedge clock);
    #1 data_en = 1'b0; ld_en = 1'b1; ld_addr = 16'h4030; ld_data = 16'h3333;
    @(posedge clock);
    #1 ld_en = 1'b0;
    @(negedge clock);
    check_eq("ldwin_cpl", complete_data, 1'b1);
    model[16'h4030] = 16'h3333;
    model12[12'h030] = 16'h3333;
    $display("ldwin [4030] port 2222 vs ld 3333");
    check_dread(16'h4030);

    // Reset in WAIT aborts the write; load during reset still lands.
    ld_write(16'h4010, 16'h7777);
    @(negedge clock);
    data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'h4010; Data_din = 16'h1234;
    @(posedge clock);
    #1 data_en = 1'b0; reset = 1'b1; ld_en = 1'b1; ld_addr = 16'h4020; ld_data = 16'hA5A5;
    @(negedge clock);
    check_eq("rst_wait_cpl", complete_data, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0; ld_en = 1'b0;
    model[16'h4020] = 16'hA5A5;
    model12[12'h020] = 16'hA5A5;
    exp_data_dout = 16'h0000;
    pulses = 0;
    repeat (6) begin
      @(negedge clock);
      if (complete_data) pulses++;
    end
    check_eq("rst_abort_pulses", pulses, 0);
    check_eq("rst_abort_ddout", Data_dout, 16'h0000);
    check_eq("rst_abort_idout", Instr_dout, 16'h0000);
    $display("reset mid-write [4010] 1234 aborted");
    check_dread(16'h4010);
    check_dread(16'h4020);

    // Request held high is recaptured after every RESP.
    pulses = 0;
    @(negedge clock);
    pc = 16'h3000; instrmem_rd = 1'b1;
    repeat (8) begin
      @(negedge clock);
      if (complete_instr) pulses++;
    end
    instrmem_rd = 1'b0;
    repeat (STALL_MAX * 8 + 4) @(negedge clock);
    if (STALL_MAX == 0) check_eq("hold_pulses", pulses, 4);
    check_eq("hold_data", Instr_dout, model[16'h3000]);
    $display("hold  [3000] %0d completions in 8 cycles", pulses);

    // Address wrap on the 12-bit instance.
    ld_write(16'hF123, 16'hAAAA);
    ld_write(16'h0123, 16'h0C0C);
    check_dread(16'hF123);
    check_eq("wrap12_data", Data_dout12, model12[12'h123]);
    check_fetch(16'hF123);
    check_eq("wrap12_instr", Instr_dout12, model12[12'h123]);
    $display("wrap  [F123] 16b %h 12b %h", Data_dout, Data_dout12);

    // Randomized mix over a small address pool.
    for (int i = 0; i < 16; i++) begin
      pool[i] = (i < 8) ? 16'(16'h3000 + i) : 16'(16'h4000 + i);
      ld_write(pool[i], 16'($urandom));
    end
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      a = pool[$urandom_range(0, 15)];
      case ($urandom_range(0, 3))
        0: ld_write(a, 16'($urandom));
        1: do_dwrite(a, 16'($urandom));
        2: check_dread(a);
        default: check_fetch(a);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lc3_mem_responder.md
# lc3_mem_responder

Synthesizable memory responder servicing the LC3 core's instruction-fetch and data-access requests. Sits opposite the core's memory ports: it captures each request, inserts a configurable number of wait states, then returns read data and a one-cycle `complete_instr` / `complete_data` pulse. A backdoor load port lets the bench preload programs starting at 16'h3000.

## Interface
Parameters:
- ADDR_W, 16: address bits decoded; upper request-address bits above ADDR_W are ignored.
- INSTR_LAT, 1: wait cycles from instruction-request capture to `complete_instr`; legal 1..15.
- DATA_LAT, 2: wait cycles from data-request capture to `complete_data`; legal 1..15.

Ports:
- clock  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  in  16  instruction fetch address.
- instrmem_rd  in  1  instruction read request.
- Instr_dout  out  16  fetched instruction.
- complete_instr  out  1  one-cycle pulse: Instr_dout valid.
- data_en  in  1  data access request.
- Data_addr  in  16  data address.
- Data_rd  in  1  1 = read, 0 = write.
- Data_din  in  16  write data.
- Data_dout  out  16  read data.
- complete_data  out  1  one-cycle pulse: data access finished.
- ld_en  in  1  backdoor write strobe.
- ld_addr  in  16  backdoor address.
- ld_data  in  16  backdoor data.

## Operation
- Storage: 2**ADDR_W x 16-bit array; not cleared by reset.
- Each port runs an independent FSM: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: request high -> capture address (and Data_rd, Data_din), load wait counter with latency, go WAIT.
  - WAIT: decrement counter; at 1 go RESP.
  - RESP: perform access, drive data, pulse complete; go IDLE. Inputs ignored outside IDLE.
- Reads in RESP return array contents at the captured address; writes commit in RESP; Data_dout unchanged on writes.
- Instr_dout / Data_dout hold last read value until the next read completes.
- Same-cycle instruction read and data write to the same address: read returns old contents (read-before-write).
- ld_en writes in the cycle asserted, any state; same-cycle collision with a RESP data write to the same address: ld_data wins.
- Address wrap: captured address taken modulo 2**ADDR_W.

## Timing
- Request sampled in IDLE at cycle N -> complete pulse and valid data in cycle N+LAT; throughput one request per LAT+1 cycles per port.
- Request held through RESP is recaptured in the following IDLE cycle (new transaction).
- Reset values: Instr_dout 0, Data_dout 0, complete_instr 0, complete_data 0, both FSMs IDLE, counters 0.
- Reset mid-transaction: transaction aborted, no write committed, no complete pulse; memory contents retained.
- Reset asserted with ld_en: backdoor write still performed.

## Configuration
- LC3_MEM_STALL_RAND_EN: defined -> a 16-bit LFSR (seed 16'hACE1 on reset, advances every cycle) adds 0..3 extra wait cycles (LFSR[1:0] at capture) per request on each port, stressing core stall logic. Undefined -> latency exactly INSTR_LAT / DATA_LAT, no LFSR logic.

## Structure
- Package `lc3_mem_pkg`: port-state enum (IDLE, WAIT, RESP), BASE_ADDR 16'h3000, max latency constant 15.
- Sub-module `lc3_mem_port_fsm`: request capture, wait counter, optional random-stall adder, RESP strobe; instantiated twice (instruction, data). Top holds the array, read muxing and backdoor write.

## Test plan
- Preload 16'h3000 = 16'h1261 via ld port; instrmem_rd with pc 16'h3000, INSTR_LAT 1 -> complete_instr one cycle later, Instr_dout 16'h1261.
- Data write 16'hBEEF to 16'h4000 then read 16'h4000, DATA_LAT 2 -> each complete_data 2 cycles after capture; read returns 16'hBEEF, Data_dout unchanged after write.
- Same-cycle instruction read and data write to 16'h3005 (old 16'h0000, new 16'h5555) -> Instr_dout 16'h0000; later fetch returns 16'h5555.
- Reset asserted in WAIT of write 16'h1234 to 16'h4010 -> no complete_data, location keeps prior value, outputs 0.
- ADDR_W 12, read Data_addr 16'hF123 -> returns contents of 16'h0123.
- With LC3_MEM_STALL_RAND_EN, 100 back-to-back fetches -> every complete_instr 1..4 cycles after capture, data matches preload.
